// File: rtl/log2_approx_pipe_if.sv
// log2_approx_pipe_if: vector input and result bundle for log2_approx_pipe.
//
// Handshake: there is no backpressure. A vector is accepted on a rising edge
// where i_en=1 and i_valid=1. A result is presented while o_valid=1, and
// downstream consumes it on a rising edge where i_en=1. While i_en=0 the whole
// pipe, including every valid bit, is frozen and o_valid is held as a level.
interface log2_approx_pipe_if #(
   parameter int DATA_W = 16,
   parameter int LANES  = 2
);
   logic                    i_en;
   logic                    i_valid;
   logic [LANES*DATA_W-1:0] i_in;
   logic                    o_valid;
   logic [LANES*DATA_W-1:0] o_log2;
   logic [LANES*DATA_W-1:0] o_in_byp;
   logic [LANES-1:0]        o_nonpos;

   modport master (
      output i_en, i_valid, i_in,
      input  o_valid, o_log2, o_in_byp, o_nonpos
   );

   modport slave (
      input  i_en, i_valid, i_in,
      output o_valid, o_log2, o_in_byp, o_nonpos
   );
endinterface

// File: rtl/log2_approx_pipe.sv
// log2_approx_pipe: multi-lane, 3-stage Mitchell log2 approximator for signed
// fixed-point words with FRAC_W fraction bits. Each lane also carries a bypass
// copy of its input aligned with the result.
//   stage 1: sign/zero check and leading-one detect
//   stage 2: mantissa normalisation and integer part
//   stage 3: optional correction, final add and output registers
// Optional feature: define LOG2_APPROX_CORR_EN to add the quadratic mantissa
// correction term in stage 3 (latency is unchanged either way).
module log2_approx_pipe #(
   parameter int DATA_W = 16,
   parameter int FRAC_W = 10,
   parameter int LANES  = 2
) (
   input logic               i_clk,
   input logic               i_rst,
   log2_approx_pipe_if.slave bus
);
   localparam int KW = $clog2(DATA_W);
   localparam logic [DATA_W-1:0] NEG_MAX = {1'b1, {(DATA_W-1){1'b0}}};
`ifdef LOG2_APPROX_CORR_EN
   localparam int PW = 2*FRAC_W + 2;
`endif

   // The integer part (k - FRAC_W) must fit in the integer field of the result.
   if (!((1 << (DATA_W - FRAC_W - 1)) > FRAC_W)) begin : g_bad_cfg
      $error("log2_approx_pipe: 2^(DATA_W-FRAC_W-1) must exceed FRAC_W");
   end

   typedef logic [LANES-1:0][DATA_W-1:0] word_vec_t;

   word_vec_t                    in_v;
   logic                         s1_valid, s2_valid, s3_valid;

   logic [LANES-1:0][KW-1:0]     s1_k, s1_k_d;
   logic [LANES-1:0]             s1_flag, s1_flag_d;
   word_vec_t                    s1_v;

   logic [LANES-1:0][FRAC_W-1:0] s2_m, s2_m_d;
   word_vec_t                    s2_int, s2_int_d;
   logic [LANES-1:0]             s2_flag;
   word_vec_t                    s2_v;

   word_vec_t                    s3_log2, s3_log2_d, s3_byp;
   logic [LANES-1:0]             s3_flag;

   assign in_v         = bus.i_in;
   assign bus.o_valid  = s3_valid;
   assign bus.o_log2   = s3_log2;
   assign bus.o_in_byp = s3_byp;
   assign bus.o_nonpos = s3_flag;

   // Stage 1 comb: flag non-positive inputs and find the leading one below the sign bit.
   always_comb begin
      s1_k_d    = '0;
      s1_flag_d = '0;
      for (int l = 0; l < LANES; l++) begin
         for (int b = 0; b < DATA_W-1; b++) begin
            if (in_v[l][b]) s1_k_d[l] = KW'(b);
         end
         s1_flag_d[l] = in_v[l][DATA_W-1] | (in_v[l] == '0);
      end
   end

   // Stage 2 comb: shift the bits below the leading one into a FRAC_W mantissa.
   always_comb begin
      int kk;
      kk       = 0;
      s2_m_d   = '0;
      s2_int_d = '0;
      for (int l = 0; l < LANES; l++) begin
         kk = int'(s1_k[l]);
         if (kk <= FRAC_W) s2_m_d[l] = FRAC_W'(s1_v[l] << (FRAC_W - kk));
         else              s2_m_d[l] = FRAC_W'(s1_v[l] >> (kk - FRAC_W));
         s2_int_d[l] = DATA_W'((kk - FRAC_W) * (2 ** FRAC_W));
      end
   end

   // Stage 3 comb: add mantissa (plus optional correction) and force flagged lanes.
   always_comb begin
      logic [FRAC_W-1:0] corr;
`ifdef LOG2_APPROX_CORR_EN
      logic [PW-1:0]     prod;
      prod = '0;
`endif
      corr      = '0;
      s3_log2_d = '0;
      for (int l = 0; l < LANES; l++) begin
`ifdef LOG2_APPROX_CORR_EN
         // corr = floor(3*m*(2^F - m) / 2^(F+3)); product stays below 2^(2F).
         prod = PW'(3) * PW'(s2_m[l]) * (PW'(2 ** FRAC_W) - PW'(s2_m[l]));
         corr = FRAC_W'(prod >> (FRAC_W + 3));
`endif
         s3_log2_d[l] = s2_flag[l] ? NEG_MAX
                                   : s2_int[l] + DATA_W'(s2_m[l]) + DATA_W'(corr);
      end
   end

   // Valid bits advance on every enabled edge, so bubbles travel as zeros.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         s1_valid <= 1'b0;
         s2_valid <= 1'b0;
         s3_valid <= 1'b0;
      end else if (bus.i_en) begin
         s1_valid <= bus.i_valid;
         s2_valid <= s1_valid;
         s3_valid <= s2_valid;
      end
   end

   // Stage 1 data: load only for an accepted input vector.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         s1_k    <= '0;
         s1_flag <= '0;
         s1_v    <= '0;
      end else if (bus.i_en && bus.i_valid) begin
         s1_k    <= s1_k_d;
         s1_flag <= s1_flag_d;
         s1_v    <= in_v;
      end
   end

   // Stage 2 data: load only when stage 1 holds a valid vector.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         s2_m    <= '0;
         s2_int  <= '0;
         s2_flag <= '0;
         s2_v    <= '0;
      end else if (bus.i_en && s1_valid) begin
         s2_m    <= s2_m_d;
         s2_int  <= s2_int_d;
         s2_flag <= s1_flag;
         s2_v    <= s1_v;
      end
   end

   // Output registers: hold the last result whenever no new vector arrives.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         s3_log2 <= '0;
         s3_byp  <= '0;
         s3_flag <= '0;
      end else if (bus.i_en && s2_valid) begin
         s3_log2 <= s3_log2_d;
         s3_byp  <= s2_v;
         s3_flag <= s2_flag;
      end
   end
endmodule

// File: tb/tb_log2_approx_pipe.sv
// tb_log2_approx_pipe: randomized and directed bench for log2_approx_pipe.
// Reference model works from the arithmetic definition (floor(log2 v), scaled
// remainder) plus a slot-level latency rule; define LOG2_APPROX_CORR_EN to
// check the corrected build.
module tb_log2_approx_pipe;
   localparam int DATA_W = 16;
   localparam int FRAC_W = 10;
   localparam int LANES  = 2;
   localparam int VW     = LANES*DATA_W;
   localparam int EW     = 2*VW + LANES;

`ifdef LOG2_APPROX_CORR_EN
   localparam logic [15:0] R0600 = 16'h0260;
   localparam logic [15:0] R0030 = 16'hEE60;
`else
   localparam logic [15:0] R0600 = 16'h0200;
   localparam logic [15:0] R0030 = 16'hEE00;
`endif

   logic clk, rst;

   log2_approx_pipe_if #(.DATA_W(DATA_W), .LANES(LANES)) bus();

   log2_approx_pipe #(.DATA_W(DATA_W), .FRAC_W(FRAC_W), .LANES(LANES)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   // clock / reset block
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, summary not printed");
      $fatal(1);
   end

   // scoreboard state
   logic [EW-1:0] exp_q[$];
   bit            vhist[$];
   logic          exp_ov;
   logic [EW-1:0] exp_out;
   int            n_vectors, n_checks, n_fail;

   logic [15:0] tbl_in  [6] = '{16'h0001, 16'h0400, 16'h0800, 16'h7FFF, 16'h0600, 16'h0030};
   logic [15:0] tbl_exp [6] = '{16'hD800, 16'h0000, 16'h0400, 16'h13FF, R0600,    R0030};

   // reference: Mitchell log2 of one lane from plain arithmetic
   function automatic logic [DATA_W-1:0] ref_lane(input logic [DATA_W-1:0] v);
      longint sv, k, m, c, r;
      sv = longint'($signed(v));
      if (sv <= 0) return {1'b1, {(DATA_W-1){1'b0}}};
      k = 0;
      while ((longint'(1) << (k + 1)) <= sv) k++;
      m = ((sv << FRAC_W) >> k) % (longint'(1) << FRAC_W);
      c = 0;
`ifdef LOG2_APPROX_CORR_EN
      c = (3 * m * ((longint'(1) << FRAC_W) - m)) / (longint'(1) << (FRAC_W + 3));
`endif
      r = (k - FRAC_W) * (longint'(1) << FRAC_W) + m + c;
      return DATA_W'(r);
   endfunction

   function automatic logic [EW-1:0] ref_vec(input logic [VW-1:0] din);
      logic [LANES-1:0]  np;
      logic [VW-1:0]     lg;
      logic [DATA_W-1:0] w;
      for (int l = 0; l < LANES; l++) begin
         w = din[l*DATA_W +: DATA_W];
         np[l] = ($signed(w) <= 0);
         lg[l*DATA_W +: DATA_W] = ref_lane(w);
      end
      return {np, din, lg};
   endfunction

   function automatic logic [DATA_W-1:0] rand_word();
      int unsigned sel, k;
      sel = $urandom_range(0, 9);
      case (sel)
         0: return '0;
         1: return DATA_W'($urandom) | {1'b1, {(DATA_W-1){1'b0}}};
         2: return {1'b0, {(DATA_W-1){1'b1}}};
         3: return DATA_W'(1);
         default: begin
            k = $urandom_range(0, DATA_W-2);
            return DATA_W'((32'd1 << k) | ($urandom & ((32'd1 << k) - 1)));
         end
      endcase
   endfunction

   function automatic logic [VW-1:0] rand_vec();
      logic [VW-1:0] v;
      for (int l = 0; l < LANES; l++) v[l*DATA_W +: DATA_W] = rand_word();
      return v;
   endfunction

   task automatic model_clear();
      exp_q.delete();
      vhist.delete();
      exp_ov  = 1'b0;
      exp_out = '0;
   endtask

   // driver: apply one cycle of inputs, then advance the model by one edge
   task automatic cycle(input logic en, input logic vld, input logic [VW-1:0] din);
      bus.i_en    = en;
      bus.i_valid = vld;
      bus.i_in    = din;
      @(posedge clk);
      #1;
      if (rst) begin
         model_clear();
      end else if (en) begin
         vhist.push_back(vld);
         if (vld) begin
            exp_q.push_back(ref_vec(din));
            n_vectors++;
         end
         exp_ov = (vhist.size() >= 3) ? vhist[vhist.size()-3] : 1'b0;
         if (vhist.size() > 3) void'(vhist.pop_front());
         if (exp_ov) exp_out = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      bus.i_en = 1'b0; bus.i_valid = 1'b0; bus.i_in = '0;
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if ({bus.o_valid, bus.o_nonpos, bus.o_in_byp, bus.o_log2} !== '0) begin
         n_fail++;
         $display("FAIL reset_async: got %h required 0", {bus.o_valid, bus.o_nonpos, bus.o_in_byp, bus.o_log2});
      end
      model_clear();
      for (int i = 0; i < 2; i++) begin
         cycle(1'b1, 1'b1, rand_vec());
         n_checks++;
         if ({bus.o_valid, bus.o_nonpos, bus.o_in_byp, bus.o_log2} !== {exp_ov, exp_out}) begin
            n_fail++;
            $display("FAIL reset_hold c%0d: got %h required %h", i, {bus.o_valid, bus.o_nonpos, bus.o_in_byp, bus.o_log2}, {exp_ov, exp_out});
         end
      end
      rst = 1'b0;
   endtask

   task automatic test_basic();
      int j;
      j = 0;
      for (int i = 0; i < 9; i++) begin
         cycle(1'b1, i < 6, (i < 6) ? {tbl_in[5-i], tbl_in[i]} : '0);
         n_checks++;
         if ({bus.o_valid, bus.o_nonpos, bus.o_in_byp, bus.o_log2} !== {exp_ov, exp_out}) begin
            n_fail++;
            $display("FAIL basic_model c%0d: got %h required %h", i, {bus.o_valid, bus.o_nonpos, bus.o_in_byp, bus.o_log2}, {exp_ov, exp_out});
         end
         if (exp_ov) begin
            n_checks++;
            if (bus.o_log2 !== {tbl_exp[5-j], tbl_exp[j]}) begin
               n_fail++;
               $display("FAIL basic_table in=%h,%h: got %h required %h", tbl_in[5-j], tbl_in[j], bus.o_log2, {tbl_exp[5-j], tbl_exp[j]});
            end
            j++;
         end
      end
   endtask

   task automatic test_nonpos();
      logic [VW-1:0] din [2]  = '{{16'h8000, 16'h0000}, {16'h0400, 16'hFFFF}};
      logic [VW-1:0] rlog [2] = '{{16'h8000, 16'h8000}, {16'h0000, 16'h8000}};
      logic [1:0]    rflg [2] = '{2'b11, 2'b01};
      int j;
      j = 0;
      for (int i = 0; i < 5; i++) begin
         cycle(1'b1, i < 2, (i < 2) ? din[i] : '0);
         n_checks++;
         if ({bus.o_valid, bus.o_nonpos, bus.o_in_byp, bus.o_log2} !== {exp_ov, exp_out}) begin
            n_fail++;
            $display("FAIL nonpos_model c%0d: got %h required %h", i, {bus.o_valid, bus.o_nonpos, bus.o_in_byp, bus.o_log2}, {exp_ov, exp_out});
         end
         if (exp_ov) begin
            n_checks++;
            if ({bus.o_nonpos, bus.o_log2} !== {rflg[j], rlog[j]}) begin
               n_fail++;
               $display("FAIL nonpos_table v%0d: got %b %h required %b %h", j, bus.o_nonpos, bus.o_log2, rflg[j], rlog[j]);
            end
            j++;
         end
      end
   endtask

   task automatic test_stream();
      int first_ov, cnt_ov;
      first_ov = -1;
      cnt_ov   = 0;
      for (int i = 0; i < 11; i++) begin
         cycle(1'b1, i < 8, (i < 8) ? rand_vec() : '0);
         n_checks++;
         if ({bus.o_valid, bus.o_nonpos, bus.o_in_byp, bus.o_log2} !== {exp_ov, exp_out}) begin
            n_fail++;
            $display("FAIL stream_model c%0d: got %h required %h", i, {bus.o_valid, bus.o_nonpos, bus.o_in_byp, bus.o_log2}, {exp_ov, exp_out});
         end
         if (bus.o_valid === 1'b1) begin
            if (first_ov < 0) first_ov = i;
            cnt_ov++;
         end
      end
      n_checks++;
      if (first_ov !== 2 || cnt_ov !== 8) begin
         n_fail++;
         $display("FAIL stream_timing: got first=%0d count=%0d required first=2 count=8", first_ov, cnt_ov);
      end
   endtask

   task automatic test_bubbles();
      bit            rov [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      logic [VW-1:0] a, b;
      a = {16'h0800, 16'h0800};
      b = {16'h0600, 16'h0600};
      for (int i = 0; i < 6; i++) begin
         cycle(1'b1, i == 0 || i == 2, (i == 0) ? a : (i == 2) ? b : '0);
         n_checks++;
         if ({bus.o_valid, bus.o_nonpos, bus.o_in_byp, bus.o_log2} !== {exp_ov, exp_out}) begin
            n_fail++;
            $display("FAIL bubble_model c%0d: got %h required %h", i, {bus.o_valid, bus.o_nonpos, bus.o_in_byp, bus.o_log2}, {exp_ov, exp_out});
         end
         n_checks++;
         if (bus.o_valid !== rov[i]) begin
            n_fail++;
            $display("FAIL bubble_valid c%0d: got %b required %b", i, bus.o_valid, rov[i]);
         end
         if (i == 2 || i == 3) begin
            n_checks++;
            if (bus.o_log2 !== {16'h0400, 16'h0400}) begin
               n_fail++;
               $display("FAIL bubble_hold c%0d: got %h required %h", i, bus.o_log2, {16'h0400, 16'h0400});
            end
         end
      end
   endtask

   task automatic test_stall();
      bit            st_en [9] = '{1, 1, 0, 0, 1, 0, 0, 1, 1};
      bit            st_vl [9] = '{1, 1, 1, 0, 0, 1, 1, 0, 0};
      bit            rov   [9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
      logic [VW-1:0] v1, v2;
      v1 = rand_vec();
      v2 = rand_vec();
      for (int i = 0; i < 9; i++) begin
         cycle(st_en[i], st_vl[i], (i == 0) ? v1 : (i == 1) ? v2 : rand_vec());
         n_checks++;
         if ({bus.o_valid, bus.o_nonpos, bus.o_in_byp, bus.o_log2} !== {exp_ov, exp_out}) begin
            n_fail++;
            $display("FAIL stall_model c%0d: got %h required %h", i, {bus.o_valid, bus.o_nonpos, bus.o_in_byp, bus.o_log2}, {exp_ov, exp_out});
         end
         n_checks++;
         if (bus.o_valid !== rov[i]) begin
            n_fail++;
            $display("FAIL stall_valid c%0d: got %b required %b", i, bus.o_valid, rov[i]);
         end
         if (i >= 4 && i <= 7) begin
            n_checks++;
            if (bus.o_in_byp !== ((i == 7) ? v2 : v1)) begin
               n_fail++;
               $display("FAIL stall_byp c%0d: got %h required %h", i, bus.o_in_byp, (i == 7) ? v2 : v1);
            end
         end
      end
      // random enable and valid mix, then drain
      for (int i = 0; i < 64; i++) begin
         if (i < 60) cycle($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6, rand_vec());
         else        cycle(1'b1, 1'b0, '0);
         n_checks++;
         if ({bus.o_valid, bus.o_nonpos, bus.o_in_byp, bus.o_log2} !== {exp_ov, exp_out}) begin
            n_fail++;
            $display("FAIL stall_rand c%0d: got %h required %h", i, {bus.o_valid, bus.o_nonpos, bus.o_in_byp, bus.o_log2}, {exp_ov, exp_out});
         end
      end
   endtask

   task automatic test_reset_midflight();
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, rand_vec());
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if ({bus.o_valid, bus.o_nonpos, bus.o_in_byp, bus.o_log2} !== '0) begin
         n_fail++;
         $display("FAIL midreset_async: got %h required 0", {bus.o_valid, bus.o_nonpos, bus.o_in_byp, bus.o_log2});
      end
      model_clear();
      for (int i = 0; i < 2; i++) cycle(1'b1, 1'b1, rand_vec());
      rst = 1'b0;
      for (int i = 0; i < 7; i++) begin
         cycle(1'b1, i == 4, (i == 4) ? {16'h0800, 16'h0800} : '0);
         n_checks++;
         if ({bus.o_valid, bus.o_nonpos, bus.o_in_byp, bus.o_log2} !== {exp_ov, exp_out}) begin
            n_fail++;
            $display("FAIL midreset_model c%0d: got %h required %h", i, {bus.o_valid, bus.o_nonpos, bus.o_in_byp, bus.o_log2}, {exp_ov, exp_out});
         end
         n_checks++;
         if (bus.o_valid !== (i == 6)) begin
            n_fail++;
            $display("FAIL midreset_valid c%0d: got %b required %b", i, bus.o_valid, i == 6);
         end
         if (i == 6) begin
            n_checks++;
            if (bus.o_log2 !== {16'h0400, 16'h0400}) begin
               n_fail++;
               $display("FAIL midreset_result: got %h required %h", bus.o_log2, {16'h0400, 16'h0400});
            end
         end
      end
   endtask

   initial begin
      n_vectors = 0;
      n_checks  = 0;
      n_fail    = 0;
      rst       = 1'b0;
      model_clear();
      test_reset();
      test_basic();
      test_nonpos();
      test_stream();
      test_bubbles();
      test_stall();
      test_reset_midflight();
      $display("checks performed: %0d", n_checks);
      $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_fail);
      $finish;
   end
endmodule
